btn_debounce: RTL and testbench
===============================

# btn_debounce

Synchronises and debounces one raw push-button pin from the Tang Nano 9K board and converts it into a clean level plus single-cycle event pulses (press, release, short, long, auto-repeat). It sits directly upstream of the LED pattern stages: those stages consume `press_pulse`/`short_pulse` as step or mode commands and `long_pulse` as a pattern-reset command instead of wiring raw pins to their resets. One instance per button.

## Interface
- `DEBOUNCE_CYCLES`, 270000, consecutive stable cycles required to accept a level change (10 ms @ 27 MHz); must be ≥1
- `LONG_CYCLES`, 27000000, held cycles after press before `long_pulse` (1 s); must be ≥1
- `REPEAT_CYCLES`, 6750000, auto-repeat period after long press (0.25 s); 0 disables repeat
- `ACTIVE_LOW`, 1, 1 = pin reads 0 when pressed (board default), 0 = active-high pin
- `clk_in`  in  1  system clock, 27 MHz
- `rst`  in  1  reset, synchronous, active-high
- `btn_in`  in  1  raw asynchronous button pin
- `btn_state`  out  1  debounced level, 1 = pressed
- `press_pulse`  out  1  one cycle on accepted press
- `release_pulse`  out  1  one cycle on accepted release
- `short_pulse`  out  1  one cycle on release before long threshold
- `long_pulse`  out  1  one cycle when hold reaches `LONG_CYCLES`
- `repeat_pulse`  out  1  one cycle every `REPEAT_CYCLES` while held past long

## Operation
- Synchroniser: two flops on `btn_in`; `p` = synchronised value, inverted when `ACTIVE_LOW`=1. Flops reset to the released pin level (1 if `ACTIVE_LOW`, else 0).
- Debounce counter `dbc` (width `$clog2(DEBOUNCE_CYCLES+1)`): if `p == btn_state`, `dbc` <= 0; else if `dbc == DEBOUNCE_CYCLES-1`, `btn_state` toggles and `dbc` <= 0; else `dbc` increments. Any glitch back to the old level restarts the count.
- FSM states IDLE, HELD, LONG; hold counter `hc` (width for `LONG_CYCLES`), repeat counter `rc` (width for `REPEAT_CYCLES`).
  - IDLE: on accepted press -> `press_pulse`, `hc` <= 0, go HELD.
  - HELD: `hc` increments; when `hc == LONG_CYCLES-1` -> `long_pulse`, `rc` <= 0, go LONG. Accepted release -> `release_pulse` + `short_pulse`, go IDLE.
  - LONG: if `REPEAT_CYCLES`≠0, `rc` increments, at `REPEAT_CYCLES-1` -> `repeat_pulse`, `rc` <= 0. Accepted release -> `release_pulse` only, go IDLE.
- Simultaneous events: release accepted in same cycle as long or repeat threshold -> release wins; no `long_pulse`/`repeat_pulse`; in HELD `short_pulse` is emitted.
- All outputs registered; at most one of press/release pulse per cycle; pulses never wider than one cycle.
- Reset (any cycle, including mid-press or mid-debounce): `btn_state`=0, all pulses 0, `dbc`=`hc`=`rc`=0, FSM IDLE, sync flops at released level. If the button is still held after reset deasserts, it is treated as a fresh press (full latency below, `press_pulse` emitted).

## Timing
- Edge numbering: edge 1 = first `clk_in` edge sampling the new `btn_in` level, held stable.
- `btn_state` and `press_pulse`/`release_pulse` (and `short_pulse`) change at edge `DEBOUNCE_CYCLES+2`.
- `long_pulse` asserted exactly `LONG_CYCLES` cycles after `press_pulse`.
- First `repeat_pulse` `REPEAT_CYCLES` cycles after `long_pulse`, then every `REPEAT_CYCLES` cycles.
- Bounce shorter than `DEBOUNCE_CYCLES` cycles: no output change.
- No backpressure; consumers must sample pulses every cycle.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=20, `REPEAT_CYCLES`=5, `ACTIVE_LOW`=1.
- Reset held 3 cycles with `btn_in`=1 -> all outputs 0; `btn_in` stays 1 for 50 cycles -> no pulses.
- `btn_in` 1->0 held 10 cycles then 0->1 -> `press_pulse` at edge 6, `release_pulse` + `short_pulse` 6 edges after release starts; `btn_state` high in between.
- Bounce: `btn_in` toggles every 2 cycles for 20 cycles then settles 1 -> no pulses, `btn_state` stays 0.
- Hold 40 cycles after accepted press -> `long_pulse` 20 cycles after `press_pulse`, `repeat_pulse` at +25, +30, +35; release -> `release_pulse` only, no `short_pulse`.
- Release accepted in the exact cycle `hc` hits 19 -> `release_pulse` + `short_pulse`, no `long_pulse`.
- Assert `rst` mid-hold (state LONG), release `rst` with pin still 0 -> outputs 0 during reset, fresh `press_pulse` 6 edges after reset release.

Source files
------------

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, stable-count debounce and a
// press/hold FSM producing registered press, release, short, long and repeat pulses.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 270000,
    parameter int unsigned LONG_CYCLES     = 27000000,
    parameter int unsigned REPEAT_CYCLES   = 6750000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk_in,
    input  logic rst,
    input  logic btn_in,
    output logic btn_state,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam int unsigned DBC_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HC_W    = $clog2(LONG_CYCLES + 1);
    localparam int unsigned RC_W    = (REPEAT_CYCLES < 1) ? 1 : $clog2(REPEAT_CYCLES + 1);
    localparam int unsigned RC_LAST = (REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1;

    localparam logic [DBC_W-1:0] DBC_END = DBC_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HC_W-1:0]  HC_END  = HC_W'(LONG_CYCLES - 1);
    localparam logic [RC_W-1:0]  RC_END  = RC_W'(RC_LAST);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [DBC_W-1:0] dbc_q, dbc_d;
    logic [HC_W-1:0]  hc_q, hc_d;
    logic [RC_W-1:0]  rc_q, rc_d;
    logic             btn_state_q, btn_state_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic             pin_c;
    logic             accept_c;

    // Synchroniser and debounce: a level change needs DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        sync1_d     = btn_in;
        sync2_d     = sync1_q;
        pin_c       = sync2_q ^ ACTIVE_LOW;
        dbc_d       = dbc_q;
        btn_state_d = btn_state_q;
        accept_c    = 1'b0;
        if (pin_c == btn_state_q) begin
            dbc_d = '0;
        end else if (dbc_q == DBC_END) begin
            dbc_d       = '0;
            btn_state_d = ~btn_state_q;
            accept_c    = 1'b1;
        end else begin
            dbc_d = dbc_q + DBC_W'(1);
        end
    end

    // Press/hold FSM; an accepted release always beats a long or repeat threshold.
    always_comb begin
        state_d   = state_q;
        hc_d      = hc_q;
        rc_d      = rc_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_c && !btn_state_q) begin
                    press_d = 1'b1;
                    hc_d    = '0;
                    state_d = ST_HELD;
                end
            end
            ST_HELD: begin
                if (accept_c) begin
                    release_d = 1'b1;
                    short_d   = 1'b1;
                    state_d   = ST_IDLE;
                end else if (hc_q == HC_END) begin
                    long_d  = 1'b1;
                    rc_d    = '0;
                    state_d = ST_LONG;
                end else begin
                    hc_d = hc_q + HC_W'(1);
                end
            end
            ST_LONG: begin
                if (accept_c) begin
                    release_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (REPEAT_CYCLES != 0) begin
                    if (rc_q == RC_END) begin
                        repeat_d = 1'b1;
                        rc_d     = '0;
                    end else begin
                        rc_d = rc_q + RC_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sync1_q     <= ACTIVE_LOW;
            sync2_q     <= ACTIVE_LOW;
            dbc_q       <= '0;
            hc_q        <= '0;
            rc_q        <= '0;
            btn_state_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            short_q     <= 1'b0;
            long_q      <= 1'b0;
            repeat_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            dbc_q       <= dbc_d;
            hc_q        <= hc_d;
            rc_q        <= rc_d;
            btn_state_q <= btn_state_d;
            press_q     <= press_d;
            release_q   <= release_d;
            short_q     <= short_d;
            long_q      <= long_d;
            repeat_q    <= repeat_d;
        end
    end

    assign btn_state     = btn_state_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign short_pulse   = short_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Randomised scoreboard bench for btn_debounce: an edge-indexed timestamp model
// pushes the expected outputs for every edge; a monitor pops and compares after each edge.
module tb_btn_debounce;

    localparam int D = 4;
    localparam int L = 20;
    localparam int R = 5;

    logic clk_in = 1'b0;
    logic rst;
    logic btn_in;
    logic btn_state, press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse;

    always #5 clk_in = ~clk_in;

    btn_debounce #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES    (L),
        .REPEAT_CYCLES  (R),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .btn_in       (btn_in),
        .btn_state    (btn_state),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .short_pulse  (short_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse)
    );

    // pulses = {press, release, short, long, repeat}
    typedef struct packed {
        logic       level;
        logic [4:0] pulses;
    } exp_t;

    exp_t exp_q[$];
    bit   in_hist[$];
    bit   rst_hist[$];
    int   checks = 0;
    int   errors = 0;
    bit   active = 1'b0;

    bit m_level   = 1'b0;
    int m_last    = 0;
    bit m_held    = 1'b0;
    int m_press_e = 0;

    // Pressed value seen by the debouncer at edge k: pin from edge k-2, released while reset flushes the synchroniser.
    function automatic bit pressed_at(int k);
        if (k < 3) return 1'b0;
        if (rst_hist[k-2] || rst_hist[k-3]) return 1'b0;
        return !in_hist[k-3];
    endfunction

    task automatic drive_edge(input bit pin, input bit r);
        exp_t x;
        int   e;
        int   d;
        bit   win;
        in_hist.push_back(pin);
        rst_hist.push_back(r);
        e = in_hist.size();
        x.pulses = '0;
        if (r) begin
            m_level = 1'b0;
            m_last  = e;
            m_held  = 1'b0;
        end else begin
            win = (e - m_last >= D);
            for (int i = 0; i < D; i++)
                if (win && pressed_at(e - i) == m_level) win = 1'b0;
            if (win) begin
                m_level = !m_level;
                m_last  = e;
                if (m_level) begin
                    x.pulses[4] = 1'b1;
                    m_held      = 1'b1;
                    m_press_e   = e;
                end else begin
                    x.pulses[3] = 1'b1;
                    if (e - m_press_e <= L) x.pulses[2] = 1'b1;
                    m_held = 1'b0;
                end
            end else if (m_held) begin
                d = e - m_press_e;
                if (d == L) x.pulses[1] = 1'b1;
                else if (d > L && ((d - L) % R) == 0) x.pulses[0] = 1'b1;
            end
        end
        x.level = m_level;
        exp_q.push_back(x);
        btn_in = pin;
        rst    = r;
        @(posedge clk_in);
        #1;
    endtask

    task automatic seg(input bit pin, input int n, input bit r);
        repeat (n) drive_edge(pin, r);
    endtask

    // Monitor: every edge is an output beat; compare pulses and level against the scoreboard.
    initial begin
        exp_t       want;
        logic [4:0] obs;
        int         edge_n;
        edge_n = 0;
        forever begin
            @(posedge clk_in);
            #2;
            if (active) begin
                edge_n++;
                obs = {press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty edge %0d got pulses %b want an expected entry", edge_n, obs);
                end else begin
                    want = exp_q.pop_front();
                    if (obs !== want.pulses) begin
                        errors++;
                        $display("FAIL pulses edge %0d got %b want %b", edge_n, obs, want.pulses);
                    end
                    checks++;
                    if (btn_state !== want.level) begin
                        errors++;
                        $display("FAIL btn_state edge %0d got %b want %b", edge_n, btn_state, want.level);
                    end
                end
            end
        end
    end

    initial begin
        int lens[3];
        rst    = 1'b1;
        btn_in = 1'b1;
        active = 1'b1;
        // reset, then idle released pin
        seg(1'b1, 3, 1'b1);
        seg(1'b1, 50, 1'b0);
        // short press
        seg(1'b0, 10, 1'b0);
        seg(1'b1, 12, 1'b0);
        // bounce shorter than the debounce window
        for (int i = 0; i < 10; i++) seg(1'(i % 2), 2, 1'b0);
        seg(1'b1, 12, 1'b0);
        // long hold with auto-repeat
        seg(1'b0, 46, 1'b0);
        seg(1'b1, 12, 1'b0);
        // release one before, exactly at, and one after the long threshold
        lens[0] = 19; lens[1] = 20; lens[2] = 21;
        for (int i = 0; i < 3; i++) begin
            seg(1'b0, lens[i], 1'b0);
            seg(1'b1, 12, 1'b0);
        end
        // reset while in long hold, pin still pressed afterwards
        seg(1'b0, 30, 1'b0);
        seg(1'b0, 3, 1'b1);
        seg(1'b0, 15, 1'b0);
        seg(1'b1, 12, 1'b0);
        // random segments with occasional resets and long holds
        repeat (80) begin
            int sel;
            sel = int'($urandom_range(0, 19));
            if (sel == 0)
                seg(1'($urandom_range(0, 1)), int'($urandom_range(1, 3)), 1'b1);
            else if (sel < 4)
                seg(1'($urandom_range(0, 1)), int'($urandom_range(20, 45)), 1'b0);
            else
                seg(1'($urandom_range(0, 1)), int'($urandom_range(1, 9)), 1'b0);
        end
        seg(1'b1, 12, 1'b0);
        #2;
        active = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries left want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
